// File: rtl/red_pitaya_mux_sched.sv
// Round-robin time-slot scheduler for the FADS analog input multiplexer.
// Each enabled channel gets SWITCH, an optional settle interval, then a dwell interval.
module red_pitaya_mux_sched #(
  parameter int CHNL = 6,
  parameter int CW   = 16
) (
  input  logic            adc_clk_i,
  input  logic            adc_rstn_i,
  input  logic [CHNL-1:0] active_channels_i,
  input  logic [CW-1:0]   settle_cycles_i,
  input  logic [CW-1:0]   dwell_cycles_i,
  input  logic            hold_i,
  output logic [2:0]      mux_addr_o,
  output logic            signal_stable_o,
  output logic            sample_strobe_o,
  output logic            frame_done_o,
  output logic            idle_o
);

  typedef enum logic [1:0] {IDLE, SWITCH, SETTLE, DWELL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    addr_q, addr_d;
  logic          stable_q, stable_d;
  logic          strobe_q, strobe_d;
  logic          frame_q, frame_d;
  logic          idle_q, idle_d;

  logic [7:0]    mask;
  logic [2:0]    lowest, above, next_ch;
  logic          above_found;
  logic [CW-1:0] dwell_eff;

  assign dwell_eff = (dwell_cycles_i == '0) ? CW'(1) : dwell_cycles_i;

  // Descending scan so the last hit is the lowest qualifying channel.
  always_comb begin
    mask = '0;
    mask[CHNL-1:0] = active_channels_i;
    lowest = '0;
    above = '0;
    above_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 3'(i);
        if (3'(i) > addr_q) begin
          above = 3'(i);
          above_found = 1'b1;
        end
      end
    end
    next_ch = above_found ? above : lowest;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = 1'b0;
    frame_d  = 1'b0;
    if (active_channels_i == '0) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d  = lowest;
          state_d = SWITCH;
        end
        SWITCH: begin
          if (settle_cycles_i != '0) begin
            cnt_d   = settle_cycles_i;
            state_d = SETTLE;
          end else begin
            cnt_d   = dwell_eff;
            state_d = DWELL;
          end
        end
        SETTLE: begin
          if (!mask[addr_q]) begin
            addr_d  = next_ch;
            state_d = SWITCH;
          end else if (cnt_q == CW'(1)) begin
            cnt_d   = dwell_eff;
            state_d = DWELL;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DWELL: begin
          // A pending sort decision freezes everything, including a deferred abandon.
          if (!hold_i) begin
            if (!mask[addr_q]) begin
              addr_d  = next_ch;
              state_d = SWITCH;
            end else if (cnt_q == CW'(1)) begin
              strobe_d = 1'b1;
              frame_d  = (next_ch <= addr_q);
              if (next_ch != addr_q) begin
                addr_d  = next_ch;
                state_d = SWITCH;
              end else begin
                cnt_d = dwell_eff;
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    stable_d = (state_d == DWELL);
    idle_d   = (state_d == IDLE);
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      stable_q <= 1'b0;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      stable_q <= stable_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
      idle_q   <= idle_d;
    end
  end

  assign mux_addr_o      = addr_q;
  assign signal_stable_o = stable_q;
  assign sample_strobe_o = strobe_q;
  assign frame_done_o    = frame_q;
  assign idle_o          = idle_q;

endmodule

// File: doc/red_pitaya_mux_sched.md
# red_pitaya_mux_sched

Time-slot scheduler for the analog input multiplexer of the droplet-sorting (FADS) path. It walks the enabled channels in round-robin order and drives the 3-bit multiplexer address. Per channel, it enforces a programmable settle interval followed by a programmable dwell interval, and asserts `signal_stable_o` only during dwell. It sits between the FADS core, which supplies the active-channel mask, timing and hold, and the external mux select lines (DIO2..DIO4). It replaces the fixed-timing sequencing in the mux block.

## Interface
Parameters:
- `CHNL`, 6: number of mux channels; legal range 1..8.
- `CW`, 16: width of the settle and dwell counters.

Ports:
- `adc_clk_i`  in  1  ADC clock; the only clock.
- `adc_rstn_i`  in  1  reset, synchronous, active-low.
- `active_channels_i`  in  CHNL  enable mask; bit n enables channel n.
- `settle_cycles_i`  in  CW  settle length in cycles after an address change; 0 is legal.
- `dwell_cycles_i`  in  CW  dwell length in cycles; 0 is treated as 1.
- `hold_i`  in  1  freezes the dwell counter on the current channel (sort decision pending).
- `mux_addr_o`  out  3  multiplexer address; registered.
- `signal_stable_o`  out  1  high exactly while in DWELL.
- `sample_strobe_o`  out  1  one-cycle pulse on the final dwell cycle.
- `frame_done_o`  out  1  one-cycle pulse when the sequence wraps past the highest active channel.
- `idle_o`  out  1  high in IDLE.

## Operation
- States: IDLE, SWITCH, SETTLE, DWELL. The state register, counter, address and all outputs are registered.
- Next-channel function: the lowest set mask bit strictly above the current address. If there is none, wrap to the lowest set bit overall. It uses `active_channels_i` as sampled in the deciding cycle.
- IDLE
  - `mux_addr_o` holds its last value; after reset it is 0.
  - If the mask is non-zero: load the lowest set bit into the address and go to SWITCH.
- SWITCH
  - Lasts 1 cycle; the address is stable.
  - Load the counter with `settle_cycles_i`.
  - Go to SETTLE if the loaded value is greater than 0. Otherwise go straight to DWELL with the counter loaded with `max(dwell_cycles_i, 1)`.
- SETTLE
  - Decrement the counter each cycle.
  - When the counter reaches 1, load `max(dwell_cycles_i, 1)` and go to DWELL.
- DWELL
  - `signal_stable_o` is 1.
  - Decrement the counter each cycle unless `hold_i` is 1. While held, the counter, state and address are frozen and `sample_strobe_o` is suppressed.
  - On the cycle the counter is 1 and `hold_i` is 0: pulse `sample_strobe_o` and compute the next channel.
    - If the next channel differs from the current one: update the address and go to SWITCH.
    - If the next channel equals the current one (single active channel): reload the dwell count and stay in DWELL. There is no SWITCH or SETTLE and `signal_stable_o` stays high.
  - `frame_done_o` pulses on the same cycle as `sample_strobe_o` when the chosen next channel is ≤ the current channel (wrap), including the single-channel case.
- Mask edge cases:
  - Current channel's bit cleared during SETTLE or DWELL (and `hold_i` = 0): abandon the slot. The next cycle drops `signal_stable_o` and moves to the next channel via SWITCH. There is no `sample_strobe_o` and no `frame_done_o`.
  - Mask becomes all-zero in any state: go to IDLE next cycle. The address is unchanged.
  - `hold_i` overrides mask removal. The abandon is deferred until `hold_i` falls.
- Settle and dwell values are sampled only at counter load. Changes mid-interval take effect in the next slot.
- `hold_i` outside DWELL has no effect.

## Timing
- Reset (synchronous, `adc_rstn_i` = 0 at a clock edge): the next edge gives state IDLE, `mux_addr_o` = 0, `signal_stable_o` = 0, `sample_strobe_o` = 0, `frame_done_o` = 0, `idle_o` = 1, counter = 0.
- Reset mid-operation has the same effect. Outputs return to reset values on the following edge with no pulse emitted.
- Slot length with no hold: 1 (SWITCH) + S (settle) + max(D, 1) cycles, with S = 0 allowed.
- First slot after the mask goes non-zero in IDLE: the address is valid 1 cycle later, and `signal_stable_o` rises 2 + S cycles after the mask is sampled.
- `signal_stable_o` falls on the same edge that `mux_addr_o` changes. It is never high while the address differs from the previous cycle.
- Counter widths: the counter is CW bits. A value of 2^CW − 1 is legal and there is no overflow because the counter only decrements.

## Test plan
- Reset and wake-up: CHNL = 6, mask 6'b101001, S = 3, D = 4 → address sequence 0, 3, 5, 0…; each slot is 8 cycles; `signal_stable_o` is high 4 cycles per slot; `frame_done_o` pulses on the strobe of channel 5.
- Zero timing: S = 0, D = 0, mask 6'b000011 → slot length 2 cycles; stable toggles 0/1 each cycle; one strobe per slot.
- Single channel: mask 6'b000100, D = 5 → address fixed at 2; stable constantly high after the first settle; strobe and `frame_done_o` every 5 cycles.
- Hold: assert `hold_i` for 20 cycles mid-dwell on channel 3 → address stays 3; no strobe during hold; the remaining dwell cycles complete after release; the total count equals D.
- Mask removal: clear bit 3 during channel 3 SETTLE → the next cycle moves to channel 5 via SWITCH, with no strobe. Mask → 0 during DWELL → IDLE next cycle, `idle_o` = 1, stable = 0.
- Reset mid-DWELL: assert `adc_rstn_i` = 0 for 1 cycle → all outputs at reset values on the next edge; the sequence restarts at the lowest active channel.
